// File: rtl/daq_pingpong_buf_pkg.sv
// Shared constants and read-FSM encoding for the DAQ ping-pong buffer.
package daq_pingpong_buf_pkg;

    localparam int unsigned DAQ_BUF_LEN = 2048;
    localparam int unsigned OVF_CNT_W   = 16;
    localparam int unsigned RD_ADD_W    = 11;
    localparam int unsigned RAM_DW      = 16;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_GO      = 2'd1,
        RD_BUSY    = 2'd2,
        RD_RELEASE = 2'd3
    } rd_state_t;

endpackage

// File: rtl/dp_ram_2bank.sv
// Two-bank simple dual-port RAM: one word write port, one registered byte-lane read port.
module dp_ram_2bank
    import daq_pingpong_buf_pkg::*;
#(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = RAM_DW
) (
    input  logic              clockout,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [AW-1:0]     raddr,
    input  logic              rsel_hi,
    output logic [DW/2-1:0]   rdata
);

    localparam int unsigned DEPTH = 32'(1) << AW;
    localparam int unsigned HW    = DW / 2;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clockout) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Byte lane is picked in the same register stage as the array read.
    always_ff @(posedge clockout or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rsel_hi) begin
            rdata <= mem[raddr][DW-1:HW];
        end else begin
            rdata <= mem[raddr][HW-1:0];
        end
    end

endmodule

// File: rtl/daq_pingpong_buf.sv
// Ping-pong sample buffer between the ADC sample stream and the FT232 burst sender.
module daq_pingpong_buf
    import daq_pingpong_buf_pkg::*;
#(
    parameter int unsigned BUF_LEN = DAQ_BUF_LEN,
    parameter int unsigned SMP_W   = 16
) (
    input  logic                 clockout,
    input  logic                 rst_n,
    input  logic                 acq_en,
    input  logic                 smp_valid,
    input  logic [SMP_W-1:0]     smp_data,
    input  logic [RD_ADD_W-1:0]  rd_add,
    output logic [7:0]           rd_data,
    output logic                 tr_go,
    input  logic                 tr_done,
    output logic [1:0]           bank_full,
    output logic                 ovf,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    localparam int unsigned WORDS = BUF_LEN / 2;
    localparam int unsigned PTR_W = $clog2(WORDS);
    localparam int unsigned AW    = PTR_W + 1;

    logic             wbank;
    logic             rbank;
    logic [PTR_W-1:0] wptr;
    logic             tr_done_q;
    rd_state_t        state;
    rd_state_t        state_nxt;

    logic             wr_fire;
    logic             wr_drop;
    logic             wr_wrap;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;

    // Write-side qualification and bank_full set/clear vectors (clear wins).
    always_comb begin
        wr_fire  = 1'b0;
        wr_drop  = 1'b0;
        wr_wrap  = 1'b0;
        full_set = 2'b00;
        full_clr = 2'b00;
        if (smp_valid && acq_en) begin
            wr_fire = !bank_full[wbank];
            wr_drop = bank_full[wbank];
        end
        if (wr_fire && (wptr == PTR_W'(WORDS - 1))) begin
            wr_wrap         = 1'b1;
            full_set[wbank] = 1'b1;
        end
        if (state == RD_RELEASE) begin
            full_clr[rbank] = 1'b1;
        end
    end

    always_ff @(posedge clockout or negedge rst_n) begin
        if (!rst_n) begin
            wbank     <= 1'b0;
            wptr      <= '0;
            bank_full <= 2'b00;
            ovf       <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            bank_full <= (bank_full | full_set) & ~full_clr;
            if (!acq_en) begin
                wptr <= '0;
            end else if (wr_fire) begin
                wptr <= wr_wrap ? '0 : wptr + PTR_W'(1);
                if (wr_wrap) begin
                    wbank <= ~wbank;
                end
            end
            if (wr_drop) begin
                ovf <= 1'b1;
                if (ovf_cnt != {OVF_CNT_W{1'b1}}) begin
                    ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
                end
            end
        end
    end

    // Read FSM state register; tr_go is registered from the next state.
    always_ff @(posedge clockout or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RD_IDLE;
            rbank     <= 1'b0;
            tr_done_q <= 1'b0;
            tr_go     <= 1'b0;
        end else begin
            state     <= state_nxt;
            tr_done_q <= tr_done;
            tr_go     <= (state_nxt == RD_GO);
            if (state == RD_RELEASE) begin
                rbank <= ~rbank;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE:    if (bank_full[rbank]) state_nxt = RD_GO;
            RD_GO:      state_nxt = RD_BUSY;
            RD_BUSY:    if (tr_done && !tr_done_q) state_nxt = RD_RELEASE;
            RD_RELEASE: state_nxt = RD_IDLE;
            default:    state_nxt = RD_IDLE;
        endcase
    end

    dp_ram_2bank #(
        .AW (AW),
        .DW (RAM_DW)
    ) u_ram (
        .clockout (clockout),
        .rst_n    (rst_n),
        .we       (wr_fire),
        .waddr    ({wbank, wptr}),
        .wdata    (RAM_DW'(smp_data)),
        .raddr    ({rbank, rd_add[PTR_W:1]}),
        .rsel_hi  (rd_add[0]),
        .rdata    (rd_data)
    );

endmodule

// File: tb/tb_daq_pingpong_buf.sv
// Directed self-checking bench for daq_pingpong_buf.
module tb_daq_pingpong_buf;

    logic        clockout = 1'b0;
    logic        rst_n;
    logic        acq_en;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic [10:0] rd_add;
    logic [7:0]  rd_data;
    logic        tr_go;
    logic        tr_done;
    logic [1:0]  bank_full;
    logic        ovf;
    logic [15:0] ovf_cnt;

    int total  = 0;
    int bad    = 0;
    int go_cnt = 0;

    always #5 clockout = ~clockout;

    daq_pingpong_buf dut (
        .clockout  (clockout),
        .rst_n     (rst_n),
        .acq_en    (acq_en),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .rd_add    (rd_add),
        .rd_data   (rd_data),
        .tr_go     (tr_go),
        .tr_done   (tr_done),
        .bank_full (bank_full),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
    );

    // Counts cycles with tr_go high; one 1-cycle pulse adds exactly one.
    always @(posedge clockout) begin
        if (tr_go === 1'b1) go_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clockout);
    endtask

    task automatic send(input logic [15:0] d);
        smp_valid = 1'b1;
        smp_data  = d;
        @(negedge clockout);
    endtask

    task automatic rd_chk(input string tag, input logic [10:0] a, input logic [7:0] e);
        rd_add = a;
        @(negedge clockout);
        chk(tag, 32'(rd_data), 32'(e));
    endtask

    task automatic done_pulse();
        tr_done = 1'b1;
        tick(2);
        tr_done = 1'b0;
    endtask

    initial begin
        logic [7:0] e;
        rst_n     = 1'b0;
        acq_en    = 1'b0;
        smp_valid = 1'b0;
        smp_data  = '0;
        rd_add    = '0;
        tr_done   = 1'b0;
        tick(3);

        chk("rst_bank_full", 32'(bank_full), 32'h0);
        chk("rst_tr_go",     32'(tr_go),     32'h0);
        chk("rst_ovf",       32'(ovf),       32'h0);
        chk("rst_ovf_cnt",   32'(ovf_cnt),   32'h0);
        chk("rst_rd_data",   32'(rd_data),   32'h0);
        rst_n = 1'b1;
        tick(2);

        // First bank fill and full readback.
        acq_en = 1'b1;
        for (int i = 0; i < 1024; i++) send(16'(i));
        smp_valid = 1'b0;
        tick(4);
        chk("a_bank_full", 32'(bank_full), 32'h1);
        chk("a_go_cnt",    32'(go_cnt),    32'd1);
        for (int a = 0; a < 2048; a++) begin
            e = a[0] ? 8'(a >> 9) : 8'(a >> 1);
            rd_chk("a_rd", 11'(a), e);
        end

        // Bank 1 fills while bank 0 is still busy; one sample overflows.
        for (int i = 0; i < 1025; i++) send(16'(32'h1000 + i));
        smp_valid = 1'b0;
        tick(2);
        chk("b_bank_full", 32'(bank_full), 32'h3);
        chk("b_ovf",       32'(ovf),       32'h1);
        chk("b_ovf_cnt",   32'(ovf_cnt),   32'd1);
        chk("b_go_held",   32'(go_cnt),    32'd1);
        done_pulse();
        tick(4);
        chk("b_release_once", 32'(bank_full), 32'h2);
        chk("b_go_bank1",     32'(go_cnt),    32'd2);
        rd_chk("b_rd0",    11'd0,    8'h00);
        rd_chk("b_rd1",    11'd1,    8'h10);
        rd_chk("b_rd1000", 11'd1000, 8'hF4);
        rd_chk("b_rd2047", 11'd2047, 8'h13);
        done_pulse();
        tick(4);
        chk("b_both_free", 32'(bank_full), 32'h0);
        chk("b_go_idle",   32'(go_cnt),    32'd2);

        // Partial bank discarded when acquisition is disabled.
        for (int i = 0; i < 500; i++) send(16'(32'h5A00 + i));
        acq_en = 1'b0;
        for (int i = 0; i < 20; i++) send(16'hDEAD);
        smp_valid = 1'b0;
        tick(4);
        chk("c_no_full",   32'(bank_full), 32'h0);
        chk("c_no_go",     32'(go_cnt),    32'd2);
        chk("c_ovf_cnt",   32'(ovf_cnt),   32'd1);
        acq_en = 1'b1;
        for (int i = 0; i < 1024; i++) send(16'(32'h2000 + i));
        smp_valid = 1'b0;
        tick(4);
        chk("c_bank_full", 32'(bank_full), 32'h1);
        chk("c_go",        32'(go_cnt),    32'd3);
        rd_chk("c_rd0",    11'd0,    8'h00);
        rd_chk("c_rd1",    11'd1,    8'h20);
        rd_chk("c_rd999",  11'd999,  8'h21);
        rd_chk("c_rd2047", 11'd2047, 8'h23);

        // Asynchronous reset in the middle of a burst.
        #2 rst_n = 1'b0;
        #1;
        chk("d_bank_full", 32'(bank_full), 32'h0);
        chk("d_tr_go",     32'(tr_go),     32'h0);
        chk("d_ovf",       32'(ovf),       32'h0);
        chk("d_ovf_cnt",   32'(ovf_cnt),   32'h0);
        chk("d_rd_data",   32'(rd_data),   32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk("d_no_go", 32'(go_cnt), 32'd3);
        done_pulse();
        tick(4);
        chk("d_stray_done_go",   32'(go_cnt),    32'd3);
        chk("d_stray_done_full", 32'(bank_full), 32'h0);

        // Overflow counter saturation.
        for (int i = 0; i < 2048; i++) send(16'(i));
        chk("e_both_full", 32'(bank_full), 32'h3);
        chk("e_go",        32'(go_cnt),    32'd4);
        for (int i = 0; i < 100; i++) send(16'hBEEF);
        chk("e_ovf_cnt100", 32'(ovf_cnt), 32'd100);
        chk("e_ovf",        32'(ovf),     32'h1);
        for (int i = 0; i < 69900; i++) send(16'hBEEF);
        smp_valid = 1'b0;
        tick(2);
        chk("e_ovf_sat", 32'(ovf_cnt), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
